// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: lane steering, load extension, single-outstanding memory handshake
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and complete with rsp_misalign_o=1.
module load_store_unit #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [4:0]        rsp_rd_o,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_is_load_o,
  output logic              rsp_misalign_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_funct3;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic              r_is_store;
  logic [4:0]        r_rsp_rd;
  logic [DWIDTH-1:0] r_rsp_data;
  logic              r_rsp_is_load;
  logic              r_rsp_misalign;

  logic              w_accept;
  logic              w_trap;
  logic              w_in_req;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load_data;

  assign req_ready_o = (r_state == S_IDLE) && !reset;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_in_req    = (r_state == S_REQ);

`ifdef LSU_MISALIGN_TRAP_EN
  // Half with odd address, or word (funct3[1]=1 covers 010/011/110/111) not on a 4-byte boundary.
  assign w_trap = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                  (req_funct3_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Lane selection uses only the size-relevant address bits, so misaligned halves/words align silently.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rdata_i[7:0];
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      default: w_byte = mem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  assign mem_valid_o = w_in_req;
  assign mem_we_o    = w_in_req && r_is_store;
  assign mem_be_o    = w_in_req ? w_be : 4'b0000;
  assign mem_addr_o  = w_in_req ? {r_addr[AWIDTH-1:2], 2'b00} : '0;
  assign mem_wdata_o = w_in_req ? w_wdata : '0;

  assign rsp_valid_o    = (r_state == S_RESP);
  assign rsp_rd_o       = r_rsp_rd;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_is_load_o  = r_rsp_is_load;
  assign rsp_misalign_o = r_rsp_misalign;
  assign busy_o         = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_funct3       <= 3'd0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= 5'd0;
      r_is_store     <= 1'b0;
      r_rsp_rd       <= 5'd0;
      r_rsp_data     <= '0;
      r_rsp_is_load  <= 1'b0;
      r_rsp_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3   <= req_funct3_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_rd       <= req_rd_i;
            r_is_store <= req_is_store_i;
            if (w_trap) begin
              r_state        <= S_RESP;
              r_rsp_rd       <= req_rd_i;
              r_rsp_data     <= '0;
              r_rsp_is_load  <= !req_is_store_i;
              r_rsp_misalign <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ready_i) begin
            if (r_is_store) begin
              r_state        <= S_RESP;
              r_rsp_rd       <= r_rd;
              r_rsp_data     <= '0;
              r_rsp_is_load  <= 1'b0;
              r_rsp_misalign <= 1'b0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_state        <= S_RESP;
            r_rsp_rd       <= r_rd;
            r_rsp_data     <= w_load_data;
            r_rsp_is_load  <= 1'b1;
            r_rsp_misalign <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
